// File: rtl/multicycle_main_control.sv
// Main control FSM for the 16-bit multicycle datapath: sequences fetch/decode/execute/memory/writeback
// and drives ALUOP to ALU_Control. Memory states hold until mem_ready.
module multicycle_main_control #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              PCWriteCond,
    output logic              IorD,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              MemtoReg,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [ALUOPW-1:0] ALUOP,
    output logic [1:0]        PCSource,
    output logic              illegal_op,
    output logic [3:0]        state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    localparam logic [OPW-1:0] OP_R    = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_LW   = OPW'(4'b1000);
    localparam logic [OPW-1:0] OP_SW   = OPW'(4'b1010);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'b0100);
    localparam logic [OPW-1:0] OP_J    = OPW'(4'b1100);

    localparam logic [ALUOPW-1:0] ALU_ADD  = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] ALU_SUB  = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] ALU_FUNC = ALUOPW'(2);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       opcode_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

    // Unmatched opcodes (including X/Z in four-state simulation) fall to the default and count as illegal.
    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: opcode_legal = 1'b1;
            default:                                    opcode_legal = 1'b0;
        endcase
    end

    assign illegal_op = (state_reg == S_DECODE) && !opcode_legal;

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_R:         state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    state_next = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_next = S_MEM_WRITE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOP       = ALU_ADD;
        PCSource    = 2'b00;
        case (state_reg)
            S_FETCH: begin
                // IR and PC+2 load only on the cycle the instruction word actually arrives.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOP   = ALU_FUNC;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOP       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
